// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Covers load-use bubbles, data-memory freezes and taken-branch flushes.
// A branch resolved while memory holds the pipeline is remembered in
// br_pend and replayed as a flush on the first RUN cycle after the freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is
// defined; otherwise the counter outputs are tied to zero.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_memwait,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              br_pend_q, br_pend_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lu;
  logic mw;
  logic stall_all;
  logic br_flush;
  logic lu_stall;

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
  endfunction

  // Hazard detection: register x0 never creates a dependency
  always_comb begin
    lu = ex_is_load && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) ||
          (id_use_rs2 && (id_rs2 == ex_rd)));
    mw = dmem_req && !dmem_ready;
  end

  // Next-state and stall/flush decode; memory freeze outranks branch, branch outranks load-use
  always_comb begin
    state_d       = state_q;
    br_pend_d     = br_pend_q;
    wait_cnt_d    = wait_cnt_q;
    stall_all     = 1'b0;
    br_flush      = 1'b0;
    lu_stall      = 1'b0;
    case (state_q)
      RUN: begin
        if (mw) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          if (ex_br_taken) begin
            br_pend_d = 1'b1;
          end
        end else if (ex_br_taken || br_pend_q) begin
          br_flush  = 1'b1;
          br_pend_d = 1'b0;
        end else if (lu) begin
          lu_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall_all = 1'b1;
        if (ex_br_taken) begin
          br_pend_d = 1'b1;
        end
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = sat_inc_wait(wait_cnt_q);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      br_pend_q     <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      br_pend_q     <= br_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Outputs are forced low for the whole time reset is held
  assign pc_stall    = rst_n && (stall_all || lu_stall);
  assign ifid_stall  = rst_n && (stall_all || lu_stall);
  assign idex_stall  = rst_n && stall_all;
  assign exmem_stall = rst_n && stall_all;
  assign memwb_stall = rst_n && stall_all;
  assign ifid_flush  = rst_n && br_flush;
  assign idex_flush  = rst_n && (br_flush || lu_stall);
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_loaduse_q, cnt_loaduse_d;
  logic [CNT_W-1:0] cnt_memwait_q, cnt_memwait_d;
  logic [CNT_W-1:0] cnt_flush_q,   cnt_flush_d;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic en);
    if (!en || (&v)) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Event counters; a flush event is a branch flush, live or replayed
  always_comb begin
    cnt_loaduse_d = sat_inc_cnt(cnt_loaduse_q, lu_stall);
    cnt_memwait_d = sat_inc_cnt(cnt_memwait_q, stall_all);
    cnt_flush_d   = sat_inc_cnt(cnt_flush_q, br_flush);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_loaduse_q <= '0;
      cnt_memwait_q <= '0;
      cnt_flush_q   <= '0;
    end else begin
      cnt_loaduse_q <= cnt_loaduse_d;
      cnt_memwait_q <= cnt_memwait_d;
      cnt_flush_q   <= cnt_flush_d;
    end
  end

  assign cnt_loaduse = cnt_loaduse_q;
  assign cnt_memwait = cnt_memwait_q;
  assign cnt_flush   = cnt_flush_q;
`else
  assign cnt_loaduse = '0;
  assign cnt_memwait = '0;
  assign cnt_flush   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
// Counter expectations follow HAZARD_PERF_CNT_EN the same way the design does.
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic             dmem_req, dmem_ready;
  logic             pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic             ifid_flush, idex_flush, mem_timeout;
  logic [CNT_W-1:0] cnt_loaduse, cnt_memwait, cnt_flush;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_br_taken(ex_br_taken),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .pc_stall   (pc_stall),
    .ifid_stall (ifid_stall),
    .idex_stall (idex_stall),
    .exmem_stall(exmem_stall),
    .memwb_stall(memwb_stall),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .mem_timeout(mem_timeout),
    .cnt_loaduse(cnt_loaduse),
    .cnt_memwait(cnt_memwait),
    .cnt_flush  (cnt_flush)
  );

  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, mem_timeout}
  logic [7:0] outs;
  assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                 ifid_flush, idex_flush, mem_timeout};

  localparam logic [7:0] IDLE  = 8'b0000_0000;
  localparam logic [7:0] STALL = 8'b1111_1000;
  localparam logic [7:0] LU    = 8'b1100_0010;
  localparam logic [7:0] FL    = 8'b0000_0110;
  localparam logic [7:0] TMO   = 8'b0000_0001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  logic [7:0]  exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned exp_lu  = 0;
  int unsigned exp_mw  = 0;
  int unsigned exp_fl  = 0;

  function automatic stim_t S(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic br, input logic req,
                              input logic rdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.ld = ld; s.br = br; s.req = req; s.rdy = rdy;
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_val(input int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
    return CNT_W'(v);
`else
    return (v == 32'hFFFF_FFFF) ? '1 : '0;
`endif
  endfunction

  // Drive one cycle of inputs and record what the outputs must be.
  task automatic drive_row(input stim_t s, input logic [7:0] want);
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.rd; ex_is_load = s.ld; ex_br_taken = s.br;
    dmem_req = s.req; dmem_ready = s.rdy;
    exp_q.push_back(want);
    if (want[7:3] == 5'b11111) exp_mw++;
    else if (want[7:6] == 2'b11) exp_lu++;
    if (want[2]) exp_fl++;
  endtask

  task automatic test_reset();
    logic [7:0] want;
    drive_row(S(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0), IDLE);
    void'(exp_q.pop_front());
    exp_lu = 0; exp_mw = 0; exp_fl = 0;
    #2;
    want = IDLE;
    n_total++;
    if (outs !== want) $display("FAIL reset_hold outs got %b want %b", outs, want);
    else n_pass++;
    n_total++;
    if ({cnt_loaduse, cnt_memwait, cnt_flush} !== {3{cnt_val(0)}})
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0", cnt_loaduse, cnt_memwait, cnt_flush);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (outs !== want) $display("FAIL reset_edge outs got %b want %b", outs, want);
    else n_pass++;
    drive_row(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), IDLE);
    #1 rst_n = 1'b1;
    @(negedge clk);
    want = exp_q.pop_front();
    n_total++;
    if (outs !== want) $display("FAIL reset_release outs got %b want %b", outs, want);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    st.push_back(S(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0)); wv.push_back(LU);
    st.push_back(S(5'd3, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    st.push_back(S(5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    st.push_back(S(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    st.push_back(S(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0)); wv.push_back(LU);
    st.push_back(S(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL load_use[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    for (int i = 0; i < 3; i++) begin
      st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    end
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL mem_wait[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_wait();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(FL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL branch_in_wait[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    st.push_back(S(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0)); wv.push_back(FL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    st.push_back(S(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(FL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL priority[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(IDLE);
    st.push_back(S(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1)); wv.push_back(LU);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL back_to_back[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_counters();
    n_total++;
    if (cnt_loaduse !== cnt_val(exp_lu))
      $display("FAIL cnt_loaduse got %0d want %0d", cnt_loaduse, cnt_val(exp_lu));
    else n_pass++;
    n_total++;
    if (cnt_memwait !== cnt_val(exp_mw))
      $display("FAIL cnt_memwait got %0d want %0d", cnt_memwait, cnt_val(exp_mw));
    else n_pass++;
    n_total++;
    if (cnt_flush !== cnt_val(exp_fl))
      $display("FAIL cnt_flush got %0d want %0d", cnt_flush, cnt_val(exp_fl));
    else n_pass++;
  endtask

  task automatic test_timeout();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    for (int i = 0; i < 5; i++) begin
      st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL);
    end
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)); wv.push_back(STALL | TMO);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1)); wv.push_back(STALL | TMO);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(TMO);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(TMO);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL timeout[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t st[$]; logic [7:0] wv[$]; logic [7:0] want;
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0)); wv.push_back(STALL | TMO);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0)); wv.push_back(STALL | TMO);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL pre_reset[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
    // Mid-cycle asynchronous reset while frozen with a pending branch
    #1 rst_n = 1'b0;
    #1;
    exp_lu = 0; exp_mw = 0; exp_fl = 0;
    want = IDLE;
    n_total++;
    if (outs !== want) $display("FAIL async_reset outs got %b want %b", outs, want);
    else n_pass++;
    test_counters();
    rst_n = 1'b1;
    st.delete(); wv.delete();
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    st.push_back(S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)); wv.push_back(IDLE);
    for (int i = 0; i < st.size(); i++) begin
      drive_row(st[i], wv[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (outs !== want) $display("FAIL post_reset[%0d] outs got %b want %b", i, outs, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_in_wait();
    test_priority();
    test_back_to_back();
    test_counters();
    test_timeout();
    test_counters();
    test_reset_mid_wait();
    test_counters();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
